// File: rtl/auto_code_breaker.sv
// Automatic Mastermind code breaker: keys in 4-digit guesses over SW/enter and narrows each position from LED feedback.
// Optional WAIT_FB timeout is enabled by defining AUTO_CODE_BREAKER_TIMEOUT_EN.
module auto_code_breaker #(
  parameter int SETUP_CYCLES   = 2,
  parameter int GAP_CYCLES     = 2,
  parameter int MAX_GUESSES    = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic        fb_valid,
  input  logic [7:0]  led_feedback,
  output logic [2:0]  SW,
  output logic        enter,
  output logic        busy,
  output logic        solved,
  output logic        fail,
  output logic [3:0]  guess_count,
  output logic [11:0] solution
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_GAP, S_WAIT_FB, S_UPDATE, S_DONE, S_FAIL
  } state_t;

  localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYCLES - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);
  localparam logic [3:0]  MAX_GC     = 4'(MAX_GUESSES);

  state_t           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0][2:0]  cand_q, cand_d;
  logic [7:0]       absent_q, absent_d;
  logic [3:0]       lock_q, lock_d;
  logic [3:0]       gc_q, gc_d;
  logic [7:0]       fb_q, fb_d;

`ifdef AUTO_CODE_BREAKER_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] to_q, to_d;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // Masks as they will look after applying the latched feedback.
  logic [7:0]      absent_upd;
  logic [3:0]      lock_upd;
  logic [3:0][2:0] adv_val;
  logic [3:0]      exhausted;

  always_comb begin
    absent_upd = absent_q;
    for (int i = 0; i < 4; i++) begin
      if (fb_q[2*i +: 2] == 2'b00) absent_upd[cand_q[i]] = 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pos
      logic [2:0] nxt;
      logic       found;
      // Scan downward so the smallest eligible digit above the current one wins.
      always_comb begin
        nxt   = cand_q[gi];
        found = 1'b0;
        for (int d = 7; d >= 1; d--) begin
          if (3'(d) > cand_q[gi] && !absent_upd[3'(d)]) begin
            nxt   = 3'(d);
            found = 1'b1;
          end
        end
      end
      assign lock_upd[gi]  = lock_q[gi] | (fb_q[2*gi +: 2] == 2'b10);
      assign adv_val[gi]   = nxt;
      assign exhausted[gi] = !lock_upd[gi] && !found;
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    cand_d   = cand_q;
    absent_d = absent_q;
    lock_d   = lock_q;
    gc_d     = gc_q;
    fb_d     = fb_q;
`ifdef AUTO_CODE_BREAKER_TIMEOUT_EN
    to_d     = to_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (go) begin
          cand_d   = '0;
          absent_d = '0;
          lock_d   = '0;
          gc_d     = '0;
          idx_d    = 2'd3;
          cnt_d    = '0;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = S_PULSE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_PULSE: begin
        cnt_d   = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (idx_q != 2'd0) begin
            idx_d   = idx_q - 2'd1;
            state_d = S_SETUP;
          end else begin
            gc_d    = (gc_q != 4'd15) ? gc_q + 4'd1 : gc_q;
            state_d = S_WAIT_FB;
`ifdef AUTO_CODE_BREAKER_TIMEOUT_EN
            to_d    = '0;
`endif
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WAIT_FB: begin
        // Feedback takes priority over a timeout expiring in the same cycle.
        if (fb_valid) begin
          fb_d    = led_feedback;
          state_d = S_UPDATE;
        end
`ifdef AUTO_CODE_BREAKER_TIMEOUT_EN
        else if (to_q == TO_LAST) begin
          state_d = S_FAIL;
        end else begin
          to_d = to_q + 32'd1;
        end
`endif
      end
      S_UPDATE: begin
        lock_d   = lock_upd;
        absent_d = absent_upd;
        if (&lock_upd) begin
          state_d = S_DONE;
        end else if (gc_q == MAX_GC) begin
          state_d = S_FAIL;
        end else if (|exhausted) begin
          state_d = S_FAIL;
        end else begin
          for (int i = 0; i < 4; i++) begin
            if (!lock_upd[i]) cand_d[i] = adv_val[i];
          end
          idx_d   = 2'd3;
          state_d = S_SETUP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      cand_q   <= '0;
      absent_q <= '0;
      lock_q   <= '0;
      gc_q     <= '0;
      fb_q     <= '0;
`ifdef AUTO_CODE_BREAKER_TIMEOUT_EN
      to_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      cand_q   <= cand_d;
      absent_q <= absent_d;
      lock_q   <= lock_d;
      gc_q     <= gc_d;
      fb_q     <= fb_d;
`ifdef AUTO_CODE_BREAKER_TIMEOUT_EN
      to_q     <= to_d;
`endif
    end
  end

  // idx only moves on SETUP entry, so SW stays frozen through PULSE, GAP and WAIT_FB.
  assign SW          = cand_q[idx_q];
  assign enter       = (state_q == S_PULSE);
  assign busy        = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_FAIL);
  assign solved      = (state_q == S_DONE);
  assign fail        = (state_q == S_FAIL);
  assign guess_count = gc_q;
  assign solution    = cand_q;

endmodule

// File: tb/tb_auto_code_breaker.sv
// Directed bench for auto_code_breaker: solve, refine, budget exhaustion, stray inputs, mid-round reset, feedback wait.
module tb_auto_code_breaker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, go, fb_valid;
  logic [7:0]  led_feedback;
  logic [2:0]  sw;
  logic        enter, busy, solved, fail;
  logic [3:0]  gc;
  logic [11:0] solution;

  logic        go2, fb_valid2;
  logic [7:0]  led_feedback2;
  logic [2:0]  sw2;
  logic        enter2, busy2, solved2, fail2;
  logic [3:0]  gc2;
  logic [11:0] solution2;

  int n_checks = 0;
  int n_fail   = 0;

  auto_code_breaker #(.SETUP_CYCLES(2), .GAP_CYCLES(2), .MAX_GUESSES(8), .TIMEOUT_CYCLES(16)) u_dut (
    .clk(clk), .reset(reset), .go(go), .fb_valid(fb_valid), .led_feedback(led_feedback),
    .SW(sw), .enter(enter), .busy(busy), .solved(solved), .fail(fail),
    .guess_count(gc), .solution(solution)
  );

  auto_code_breaker #(.SETUP_CYCLES(2), .GAP_CYCLES(2), .MAX_GUESSES(2), .TIMEOUT_CYCLES(16)) u_dut2 (
    .clk(clk), .reset(reset), .go(go2), .fb_valid(fb_valid2), .led_feedback(led_feedback2),
    .SW(sw2), .enter(enter2), .busy(busy2), .solved(solved2), .fail(fail2),
    .guess_count(gc2), .solution(solution2)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Feedback model: exact match, digit elsewhere in the secret, or absent.
  function automatic logic [7:0] score(input logic [11:0] g, input logic [11:0] s);
    logic [7:0] r;
    logic       hit;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (g[3*i +: 3] == s[3*i +: 3]) begin
        r[2*i +: 2] = 2'b10;
      end else begin
        hit = 1'b0;
        for (int j = 0; j < 4; j++)
          if (j != i && s[3*j +: 3] == g[3*i +: 3]) hit = 1'b1;
        r[2*i +: 2] = hit ? 2'b01 : 2'b00;
      end
    end
    return r;
  endfunction

  task automatic chk_idle(input string pfx);
    check_eq({pfx, "_sw"},       {29'd0, sw}, 32'd0);
    check_eq({pfx, "_enter"},    {31'd0, enter}, 32'd0);
    check_eq({pfx, "_busy"},     {31'd0, busy}, 32'd0);
    check_eq({pfx, "_solved"},   {31'd0, solved}, 32'd0);
    check_eq({pfx, "_fail"},     {31'd0, fail}, 32'd0);
    check_eq({pfx, "_gc"},       {28'd0, gc}, 32'd0);
    check_eq({pfx, "_solution"}, {20'd0, solution}, 32'd0);
  endtask

  // Collects the four digits of one guess; optional stray fb_valid/go injected mid-guess.
  task automatic get_guess(input int sel, input bit inject, output logic [11:0] g, output bit ok);
    int n, last;
    logic e, prev_en;
    logic [2:0] s, prev_sw;
    n = 0; last = 0; g = '0; prev_en = 1'b0; prev_sw = '0;
    for (int cyc = 0; cyc < 200 && n < 4; cyc++) begin
      @(negedge clk);
      go = 1'b0; fb_valid = 1'b0; go2 = 1'b0; fb_valid2 = 1'b0;
      if (inject && cyc == 1) fb_valid = 1'b1;
      if (inject && cyc == 7) go = 1'b1;
      e = sel ? enter2 : enter;
      s = sel ? sw2 : sw;
      if (prev_en) check_eq("sw_hold_after_enter", {29'd0, s}, {29'd0, prev_sw});
      if (e) begin
        if (n > 0) check_eq("enter_spacing", cyc - last, 32'd5);
        g[3*(3-n) +: 3] = s;
        last = cyc;
        prev_sw = s;
        n++;
      end
      prev_en = e;
    end
    ok = (n == 4);
  endtask

  // Called on the PULSE cycle of digit 0; WAIT_FB begins three cycles later.
  task automatic send_fb(input int sel, input logic [7:0] fb, input logic [3:0] exp_gc);
    repeat (3) @(negedge clk);
    if (sel == 0) begin
      check_eq("gc_in_wait", {28'd0, gc}, {28'd0, exp_gc});
      led_feedback = fb; fb_valid = 1'b1;
    end else begin
      check_eq("gc2_in_wait", {28'd0, gc2}, {28'd0, exp_gc});
      led_feedback2 = fb; fb_valid2 = 1'b1;
    end
    @(negedge clk);
    fb_valid = 1'b0; fb_valid2 = 1'b0;
  endtask

  task automatic count_enters(input int sel, input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (sel ? enter2 : enter) n++;
    end
  endtask

  logic [11:0] exp_b [8];
  logic [11:0] g;
  bit          ok;
  int          n;

  initial begin
    exp_b = '{12'o0000, 12'o1111, 12'o2221, 12'o3331, 12'o4431, 12'o5531, 12'o6531, 12'o7531};
    reset = 1'b1; go = 1'b0; fb_valid = 1'b0; led_feedback = '0;
    go2 = 1'b0; fb_valid2 = 1'b0; led_feedback2 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_idle("rst");

    // Secret 0000 with stray fb_valid in SETUP and stray go mid-guess.
    go = 1'b1;
    get_guess(0, 1'b1, g, ok);
    check_eq("A_got4", {31'd0, ok}, 32'd1);
    check_eq("A_guess", {20'd0, g}, 32'o0000);
    $display("A guess 1: %o", g);
    send_fb(0, score(g, 12'o0000), 4'd1);
    repeat (2) @(negedge clk);
    check_eq("A_solved", {31'd0, solved}, 32'd1);
    check_eq("A_busy", {31'd0, busy}, 32'd0);
    check_eq("A_gc", {28'd0, gc}, 32'd1);
    check_eq("A_solution", {20'd0, solution}, 32'd0);
    count_enters(0, 20, n);
    check_eq("A_no_more_enter", n, 32'd0);

    // Secret 7531, started from DONE.
    go = 1'b1;
    for (int k = 0; k < 8; k++) begin
      get_guess(0, 1'b0, g, ok);
      check_eq("B_got4", {31'd0, ok}, 32'd1);
      check_eq("B_guess", {20'd0, g}, {20'd0, exp_b[k]});
      $display("B guess %0d: %o fb %b", k + 1, g, score(g, 12'o7531));
      send_fb(0, score(g, 12'o7531), 4'(k + 1));
    end
    repeat (2) @(negedge clk);
    check_eq("B_solved", {31'd0, solved}, 32'd1);
    check_eq("B_fail", {31'd0, fail}, 32'd0);
    check_eq("B_solution", {20'd0, solution}, 32'o7531);
    check_eq("B_gc", {28'd0, gc}, 32'd8);

    // Reset in the GAP after digit 2 of guess 2.
    go = 1'b1;
    get_guess(0, 1'b0, g, ok);
    check_eq("C_guess1", {20'd0, g}, 32'o0000);
    send_fb(0, score(g, 12'o7531), 4'd1);
    n = 0;
    for (int c = 0; c < 100 && n < 2; c++) begin
      @(negedge clk);
      if (enter) n++;
    end
    check_eq("C_two_enters", n, 32'd2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_idle("C_rst");
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check_eq("C_restart_sw", {29'd0, sw}, 32'd0);
    check_eq("C_restart_busy", {31'd0, busy}, 32'd1);
    get_guess(0, 1'b0, g, ok);
    check_eq("C_got4", {31'd0, ok}, 32'd1);
    check_eq("C_guess", {20'd0, g}, 32'o0000);
    $display("C guess 1 after reset: %o", g);

    // No feedback: WAIT_FB starts 3 cycles after the last enter.
`ifdef AUTO_CODE_BREAKER_TIMEOUT_EN
    repeat (18) @(negedge clk);
    check_eq("T_fail_before", {31'd0, fail}, 32'd0);
    @(negedge clk);
    check_eq("T_fail_at_16", {31'd0, fail}, 32'd1);
    check_eq("T_busy", {31'd0, busy}, 32'd0);
`else
    repeat (19) @(negedge clk);
    check_eq("T_busy_waiting", {31'd0, busy}, 32'd1);
    check_eq("T_no_fail", {31'd0, fail}, 32'd0);
    check_eq("T_gc", {28'd0, gc}, 32'd1);
`endif
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Budget of 2 against secret 7777.
    go2 = 1'b1;
    get_guess(1, 1'b0, g, ok);
    check_eq("D_guess1", {20'd0, g}, 32'o0000);
    $display("D guess 1: %o", g);
    send_fb(1, score(g, 12'o7777), 4'd1);
    get_guess(1, 1'b0, g, ok);
    check_eq("D_guess2", {20'd0, g}, 32'o1111);
    $display("D guess 2: %o", g);
    send_fb(1, score(g, 12'o7777), 4'd2);
    repeat (2) @(negedge clk);
    check_eq("D_fail", {31'd0, fail2}, 32'd1);
    check_eq("D_solved", {31'd0, solved2}, 32'd0);
    check_eq("D_busy", {31'd0, busy2}, 32'd0);
    check_eq("D_gc", {28'd0, gc2}, 32'd2);
    count_enters(1, 40, n);
    check_eq("D_no_more_enter", n, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
